// File: rtl/product_accumulator_if.sv
// Product/result handshake bundle for product_accumulator.
// Latency: none (wires only); backpressure via prod_ready and acc_ready.
// Ports: master = product source / result sink, slave = the accumulator.
interface product_accumulator_if #(
  parameter int N     = 8,
  parameter int ACC_W = 2*N+4,
  parameter int CNT_W = 8
);
  logic               prod_valid;
  logic               prod_ready;
  logic [2*N-1:0]     product;
  logic               prod_last;
  logic               acc_valid;
  logic               acc_ready;
  logic [ACC_W-1:0]   acc_out;
  logic [CNT_W-1:0]   acc_count;
  logic               acc_ovf;

  modport master (
    output prod_valid, product, prod_last, acc_ready,
    input  prod_ready, acc_valid, acc_out, acc_count, acc_ovf
  );

  modport slave (
    input  prod_valid, product, prod_last, acc_ready,
    output prod_ready, acc_valid, acc_out, acc_count, acc_ovf
  );
endinterface

// File: rtl/product_accumulator.sv
// Saturating accumulator of signed products, grouped by prod_last, with a held result.
// Latency: result presented the cycle after the last product is accepted.
// Backpressure: no products accepted while a result waits for acc_ready.
// Ports: clk, rst (sync, active-high); bus (slave side) carries the product
// input handshake (prod_valid/prod_ready/product/prod_last) and the result
// handshake (acc_valid/acc_ready/acc_out/acc_count/acc_ovf).
module product_accumulator #(
  parameter int N     = 8,
  parameter int ACC_W = 2*N+4,
  parameter int CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  product_accumulator_if.slave  bus
);

  if (ACC_W < 2*N+1) begin : g_bad_acc_w
    $error("product_accumulator: ACC_W must be at least 2N+1");
  end

  typedef enum logic {
    ACCUM   = 1'b0,
    PRESENT = 1'b1
  } state_t;

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [CNT_W-1:0]        CNT_MAX = {CNT_W{1'b1}};

  state_t                   state;
  state_t                   state_nxt;
  logic signed [ACC_W-1:0]  acc_q;
  logic [CNT_W-1:0]         cnt_q;
  logic                     ovf_q;

  logic                     take;
  logic                     release_res;
  logic signed [ACC_W:0]    prod_ext;
  logic signed [ACC_W:0]    acc_ext;
  logic signed [ACC_W:0]    sum;
  logic                     sum_ovf;
  logic signed [ACC_W-1:0]  sum_sat;

  // FSM: next state and handshake outputs.
  always_comb begin
    state_nxt      = state;
    bus.prod_ready = 1'b0;
    bus.acc_valid  = 1'b0;
    take           = 1'b0;
    release_res    = 1'b0;
    case (state)
      ACCUM: begin
        bus.prod_ready = 1'b1;
        take           = bus.prod_valid;
        if (bus.prod_valid && bus.prod_last) begin
          state_nxt = PRESENT;
        end
      end
      PRESENT: begin
        bus.acc_valid = 1'b1;
        release_res   = bus.acc_ready;
        if (bus.acc_ready) begin
          state_nxt = ACCUM;
        end
      end
      default: state_nxt = ACCUM;
    endcase
  end

  // One guard bit above the accumulator: the two top bits of the sum
  // disagree exactly when the true result does not fit in ACC_W bits.
  always_comb begin
    prod_ext = {{(ACC_W+1-2*N){bus.product[2*N-1]}}, bus.product};
    acc_ext  = {acc_q[ACC_W-1], acc_q};
    sum      = acc_ext + prod_ext;
    sum_ovf  = sum[ACC_W] ^ sum[ACC_W-1];
    if (!sum_ovf) begin
      sum_sat = sum[ACC_W-1:0];
    end else if (sum[ACC_W]) begin
      sum_sat = ACC_MIN;
    end else begin
      sum_sat = ACC_MAX;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACCUM;
      acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (take) begin
        acc_q <= sum_sat;
        if (cnt_q != CNT_MAX) begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
        ovf_q <= ovf_q | sum_ovf;
      end else if (release_res) begin
        acc_q <= '0;
        cnt_q <= '0;
        ovf_q <= 1'b0;
      end
    end
  end

  assign bus.acc_out   = acc_q;
  assign bus.acc_count = cnt_q;
  assign bus.acc_ovf   = ovf_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: directed scenarios plus random groups,
// compared against a group-level saturating-sum model.
// Ports: drives the master side of product_accumulator_if.
module tb_product_accumulator;
  localparam int N     = 8;
  localparam int ACC_W = 20;
  localparam int CNT_W = 8;
  localparam longint ACC_MAX = (longint'(1) <<< (ACC_W-1)) - 1;
  localparam longint ACC_MIN = -(longint'(1) <<< (ACC_W-1));
  localparam int     CNT_LIM = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  product_accumulator_if #(.N(N), .ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

  product_accumulator #(.N(N), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  // Model: running group sum clamped after each product, sticky overflow,
  // saturating product count, and whether a finished group is waiting.
  longint m_sum;
  int     m_cnt;
  bit     m_ovf;
  bit     m_present;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    m_sum = 0;
    m_cnt = 0;
    m_ovf = 1'b0;
    m_present = 1'b0;
  endtask

  task automatic model_step();
    if (rst) begin
      clear_model();
    end else if (!m_present) begin
      if (bus.prod_valid) begin
        m_sum = m_sum + longint'($signed(bus.product));
        if (m_sum > ACC_MAX) begin
          m_sum = ACC_MAX;
          m_ovf = 1'b1;
        end else if (m_sum < ACC_MIN) begin
          m_sum = ACC_MIN;
          m_ovf = 1'b1;
        end
        if (m_cnt < CNT_LIM) m_cnt++;
        if (bus.prod_last) m_present = 1'b1;
      end
    end else if (bus.acc_ready) begin
      clear_model();
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".prod_ready"}, longint'(bus.prod_ready), longint'(!m_present));
    check({tag, ".acc_valid"},  longint'(bus.acc_valid),  longint'(m_present));
    check({tag, ".acc_out"},    longint'($signed(bus.acc_out)), m_sum);
    check({tag, ".acc_count"},  longint'(bus.acc_count),  longint'(m_cnt));
    check({tag, ".acc_ovf"},    longint'(bus.acc_ovf),    longint'(m_ovf));
  endtask

  task automatic cyc(input bit v, input logic [2*N-1:0] p, input bit last,
                     input bit rdy, input string tag);
    bus.prod_valid = v;
    bus.product    = p;
    bus.prod_last  = last;
    bus.acc_ready  = rdy;
    tick();
    check_all(tag);
  endtask

  initial begin
    int len;
    int w;
    bit big;
    bit neg;
    logic [2*N-1:0] p;

    rst = 1'b1;
    bus.prod_valid = 1'b0;
    bus.product    = '0;
    bus.prod_last  = 1'b0;
    bus.acc_ready  = 1'b0;
    clear_model();
    tick();
    tick();
    rst = 1'b0;
    check_all("reset");
    check("reset.prod_ready_const", longint'(bus.prod_ready), 1);
    check("reset.acc_out_const", longint'($signed(bus.acc_out)), 0);

    // Basic group 3, -5, 10.
    cyc(1, 16'd3, 0, 1, "basic");
    cyc(1, -16'sd5, 0, 1, "basic");
    cyc(1, 16'd10, 1, 1, "basic");
    check("basic.valid_const", longint'(bus.acc_valid), 1);
    check("basic.out_const", longint'($signed(bus.acc_out)), 8);
    check("basic.count_const", longint'(bus.acc_count), 3);
    check("basic.ovf_const", longint'(bus.acc_ovf), 0);
    cyc(0, 16'd0, 0, 1, "basic.clear");
    check("basic.cleared_out", longint'($signed(bus.acc_out)), 0);
    check("basic.cleared_valid", longint'(bus.acc_valid), 0);

    // Backpressure: result held, offered product ignored.
    cyc(1, 16'd100, 0, 0, "bp");
    cyc(1, 16'd200, 1, 0, "bp");
    for (int i = 0; i < 4; i++) begin
      cyc(1, 16'd55, 0, 0, "bp.hold");
      check("bp.out_const", longint'($signed(bus.acc_out)), 300);
      check("bp.ready_const", longint'(bus.prod_ready), 0);
      check("bp.count_const", longint'(bus.acc_count), 2);
    end
    cyc(0, 16'd0, 0, 1, "bp.release");

    // Positive saturation.
    for (int i = 1; i <= 17; i++) cyc(1, 16'd32767, i == 17, 0, "psat");
    check("psat.out_const", longint'($signed(bus.acc_out)), 524287);
    check("psat.ovf_const", longint'(bus.acc_ovf), 1);
    check("psat.count_const", longint'(bus.acc_count), 17);
    cyc(0, 16'd0, 0, 1, "psat.release");

    // Negative saturation.
    for (int i = 1; i <= 17; i++) cyc(1, 16'h8000, i == 17, 0, "nsat");
    check("nsat.out_const", longint'($signed(bus.acc_out)), -524288);
    check("nsat.ovf_const", longint'(bus.acc_ovf), 1);
    cyc(0, 16'd0, 0, 1, "nsat.release");

    // Reset mid-stream, with a product offered during the reset edge.
    cyc(1, 16'd7, 0, 1, "rstmid");
    cyc(1, 16'd9, 0, 1, "rstmid");
    rst = 1'b1;
    cyc(1, 16'd99, 0, 1, "rstmid.rst");
    rst = 1'b0;
    cyc(1, 16'd4, 1, 0, "rstmid");
    check("rstmid.out_const", longint'($signed(bus.acc_out)), 4);
    check("rstmid.count_const", longint'(bus.acc_count), 1);
    check("rstmid.ovf_const", longint'(bus.acc_ovf), 0);

    // Reset while a result is pending drops it.
    rst = 1'b1;
    cyc(0, 16'd0, 0, 0, "rstpres");
    rst = 1'b0;
    check("rstpres.valid_const", longint'(bus.acc_valid), 0);

    // Gaps; prod_last on an idle cycle has no effect.
    cyc(1, 16'd5, 0, 0, "gap");
    cyc(0, 16'h7777, 1, 0, "gap.idle");
    cyc(1, 16'd6, 1, 0, "gap");
    check("gap.out_const", longint'($signed(bus.acc_out)), 11);
    cyc(0, 16'd0, 0, 1, "gap.release");

    // Count limit.
    for (int i = 0; i < 300; i++) cyc(1, 16'd1, 0, 0, "cnt");
    check("cnt.count_const", longint'(bus.acc_count), 255);
    cyc(1, 16'd1, 1, 0, "cnt.last");
    cyc(0, 16'd0, 0, 1, "cnt.release");

    // Random groups with gaps, stalls and occasional reset.
    for (int g = 0; g < 30; g++) begin
      len = ($urandom_range(0, 4) == 0) ? 20 : int'($urandom_range(1, 6));
      big = ($urandom_range(0, 2) == 0);
      neg = 1'($urandom_range(0, 1));
      for (int k = 0; k < len; ) begin
        if ($urandom_range(0, 3) == 0) begin
          cyc(0, 16'($urandom), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), "rnd.gap");
        end else begin
          if (big) p = neg ? 16'($urandom_range(32768, 33000))
                           : 16'($urandom_range(32500, 32767));
          else     p = 16'($urandom);
          cyc(1, p, k == len - 1, 1'($urandom_range(0, 1)), "rnd.prod");
          k++;
          if (bus.acc_valid) k = len;
        end
        if (g % 7 == 3 && k == 1) begin
          rst = 1'b1;
          cyc(1'($urandom_range(0, 1)), 16'($urandom), 0, 0, "rnd.rst");
          rst = 1'b0;
        end
      end
      w = int'($urandom_range(0, 3));
      for (int j = 0; j < w; j++) begin
        cyc(1'($urandom_range(0, 1)), 16'($urandom), 1, 0, "rnd.hold");
      end
      cyc(0, 16'd0, 0, 1, "rnd.release");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/product_accumulator.md
PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 Parameter N, default 8: multiplier operand width; the product input is 2N bits, signed two's complement.
REQ-002 Parameter ACC_W, default 2N+4: accumulator width; must be at least 2N+1.
REQ-003 Parameter CNT_W, default 8: product-count width.
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 clk  in  1  sole clock; all state changes on its rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 prod_valid  in  1  the product input holds a valid product.
REQ-008 prod_ready  out  1  the block accepts a product this cycle.
REQ-009 product  in  2N  signed multiplier result.
REQ-010 prod_last  in  1  qualifies the final product of a dot-product group; sampled with product.
REQ-011 acc_valid  out  1  the accumulated result is presented.
REQ-012 acc_ready  in  1  the consumer takes the result this cycle.
REQ-013 acc_out  out  ACC_W  signed accumulated sum.
REQ-014 acc_count  out  CNT_W  number of products in the group.
REQ-015 acc_ovf  out  1  sticky flag: saturation occurred within the group.

Function
REQ-016 The block shall implement a two-state FSM: ACCUM and PRESENT.
REQ-017 In ACCUM: prod_ready=1 and acc_valid=0.
REQ-018 In PRESENT: prod_ready=0 and acc_valid=1.
REQ-019 A transfer occurs when prod_valid and prod_ready are both 1 at the clock edge.
REQ-020 On a transfer, the block shall add the sign-extended product to the accumulator register.
REQ-021 On a transfer, acc_count shall increment; at 2^CNT_W-1 it saturates (holds) and does not wrap.
REQ-022 Addition shall be signed at ACC_W+1 bits.
  - On a positive overflow, the result is 2^(ACC_W-1)-1.
  - On a negative overflow, the result is -2^(ACC_W-1).
  - Either case sets acc_ovf=1, which stays set until the group clears.
REQ-023 A transfer with prod_last=1 shall include that product in the sum, then move the FSM to PRESENT on the same edge.
  - acc_valid is asserted in the cycle immediately after the last product is accepted (latency of 1 cycle).
REQ-024 While in PRESENT, acc_out, acc_count and acc_ovf shall hold stable until the handshake completes; prod_valid and product are ignored.
REQ-025 In PRESENT, when acc_ready=1, the edge shall clear the accumulator, acc_count and acc_ovf to 0 and return the FSM to ACCUM.
  - A new product can be accepted in the next cycle; there is no same-cycle bypass.
REQ-026 acc_out, acc_count and acc_ovf shall be driven directly from registers in every state, including the running partial sum during ACCUM.
REQ-027 When prod_valid=0 in ACCUM, all state shall hold.
REQ-028 prod_last on a non-transfer cycle shall have no effect.
REQ-029 A group of a single product with prod_last=1 shall present that product sign-extended, with acc_count=1.

Reset
REQ-030 When rst=1 at a clock edge, the FSM shall go to ACCUM and the following shall be cleared to 0: accumulator, acc_count, acc_ovf and acc_valid.
  - prod_ready=1 in the cycle after reset.
REQ-031 rst shall take priority over any simultaneous transfer or handshake.
  - An in-progress group is discarded without being presented.
  - A pending result in PRESENT is dropped.

Verification (N=8, ACC_W=20, CNT_W=8)
REQ-032 Basic group: products 3, -5, 10 (last on 10), acc_ready=1 → one cycle later acc_valid=1, acc_out=8, acc_count=3, acc_ovf=0; next cycle, state is cleared.
REQ-033 Backpressure: group 100, 200 (last), acc_ready held 0 for 4 cycles → acc_valid=1 and acc_out=300 stay stable, prod_ready=0 throughout, and a product offered meanwhile is not accepted and not summed.
REQ-034 Positive saturation: 17 transfers of 32767, last on the 17th → acc_out=524287, acc_ovf=1, acc_count=17.
REQ-035 Negative saturation: 17 transfers of -32768, last on the 17th → acc_out=-524288, acc_ovf=1.
REQ-036 Reset mid-stream: 7, 9 accepted, rst pulsed for 1 cycle, then 4 (last) → acc_out=4, acc_count=1, acc_ovf=0.
REQ-037 Gaps and count limit:
  - prod_valid toggling 1-0-1 with products 5, X, 6 (last) → acc_out=11.
  - 300 transfers with no last → acc_count holds at 255.
